seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Multiplexed 8-digit seven-segment driver. It consumes the slow scan clock from the board clock divider (~500 Hz from 100 MHz).
- It samples that scan clock in the system clock domain and steps through the digits one at a time.
- Each step decodes one 4-bit nibble of a 32-bit display word into active-low segment and anode drives.
- Data is latched once per frame to prevent tearing, and a short all-off gap is inserted between digits to suppress ghosting.

Parameters:
- DIGITS, 8, number of digits scanned (index 0..DIGITS-1); max 8.
- BLANK_CYCLES, 16, clk cycles all anodes are held off before each new digit; must be >=1.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- scan_clk  in  1  divided scan clock; treated as asynchronous-ish and synchronized internally
- data  in  32  display word; digit i shows data[4i+3:4i]
- dp  in  8  decimal point per digit, 1 = lit
- digit_en  in  8  per-digit enable; 0 keeps that anode off during its slot
- an  out  8  anode drives, active low, one-hot-low when showing
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- seg_dp  out  1  decimal point, active low
- cur_digit  out  3  index of the digit currently driven or being blanked

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst. All state is updated on posedge clk.
- Synchronizer and tick:
  - scan_clk passes through a 2-FF synchronizer (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3.
  - A rising edge of scan_clk produces exactly one tick, 2-3 clk cycles later. Falling edges are ignored.
- States:
  - IDLE: after reset, waiting for the first tick.
  - BLANK: counting BLANK_CYCLES.
  - SHOW: driving one digit.
- Transitions:
  - IDLE --tick--> BLANK with idx preset to DIGITS-1, so the first digit shown is 0.
  - SHOW --tick--> BLANK.
  - BLANK --(cnt == BLANK_CYCLES-1)--> SHOW. On this transition:
    - idx <= (idx == DIGITS-1) ? 0 : idx+1.
    - If the new idx is 0, latch data/dp/digit_en into frame registers.
- Tick in BLANK or IDLE→BLANK cycle: ignored (no queuing). The blank counter is not restarted.
- Timing: tick in cycle T gives an = 8'hFF in cycles T+1..T+BLANK_CYCLES, and new digit outputs are valid from T+BLANK_CYCLES+1.
- Outputs in SHOW:
  - an = ~(1 << idx) if frame_en[idx], else 8'hFF.
  - seg = hex decode of frame nibble idx.
  - seg_dp = ~frame_dp[idx].
  - All outputs are registered.
- Outputs in BLANK/IDLE: an = 8'hFF, seg = 7'h7F, seg_dp = 1.
- Hex table (seg, active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Frame latch:
  - Display changes to data only take effect at the start of the next frame (digit 0).
  - Mid-frame changes are invisible until then.
- Reset:
  - Values: an=8'hFF, seg=7'h7F, seg_dp=1, cur_digit=0, state=IDLE, frame regs=0, cnt=0, s1/s2/s3=0.
  - A reset asserted mid-SHOW or mid-BLANK blanks outputs on the next edge and aborts the frame.
- Wrap: cur_digit goes DIGITS-1 → 0. With DIGITS<8, unused anodes stay high permanently.
- scan_clk held constant: outputs freeze on the current digit (SHOW persists). This is acceptable and has no timeout.

Decomposition:
- Shared package seg7_pkg:
  - localparams SEG_BLANK = 7'h7F and AN_OFF = 8'hFF.
  - State encoding typedef/localparams IDLE/BLANK/SHOW.
  - The 16-entry hex segment table as a function hex_to_seg.
- One sub-module: seg7_decode, a purely combinational nibble → seg lookup using hex_to_seg. It is instantiated once, and its output is registered in seg7_scan.
- The synchronizer is inline and not a separate module.

Test Plan:
- Reset with rst=1 for 3 cycles, then scan_clk static → an=FF, seg=7F, seg_dp=1, cur_digit=0 indefinitely.
- Sequential scan with data=32'h76543210, dp=8'h01, digit_en=FF, scan_clk period 40 clk, BLANK_CYCLES=16:
  - Digits 0..7 appear in order with an=FE,FD,...,7F.
  - seg=40,79,24,30,19,12,02,78.
  - seg_dp=0 only on digit 0.
  - Each digit is preceded by exactly 16 cycles of an=FF.
- Frame latch: change data from 32'h76543210 to 32'hFEDCBA98 while digit 3 is showing → digits 4-7 still show 4-7. From the next digit 0: seg=00,10,08,03,46,21,06,0E.
- Enables: digit_en=8'hA5 → an stays FF during slots 1,3,4,6; slots 0,2,5,7 drive FE,FB,DF,7F.
- Edge timing: a scan_clk pulse 3 clk wide gives one tick and one step. Two rising edges 10 clk apart (inside the blank window) give only one digit advance.
- Reset mid-frame: assert rst during digit 5 SHOW → next edge an=FF, seg=7F. After release, the first tick shows digit 0 with newly latched data.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, scan FSM states and the hex-to-segment table for the
// multiplexed seven-segment driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] segBits;
        segBits = SEG_BLANK;
        case (nibble)
            4'h0: segBits = 7'h40;
            4'h1: segBits = 7'h79;
            4'h2: segBits = 7'h24;
            4'h3: segBits = 7'h30;
            4'h4: segBits = 7'h19;
            4'h5: segBits = 7'h12;
            4'h6: segBits = 7'h02;
            4'h7: segBits = 7'h78;
            4'h8: segBits = 7'h00;
            4'h9: segBits = 7'h10;
            4'hA: segBits = 7'h08;
            4'hB: segBits = 7'h03;
            4'hC: segBits = 7'h46;
            4'hD: segBits = 7'h21;
            4'hE: segBits = 7'h06;
            4'hF: segBits = 7'h0E;
            default: segBits = SEG_BLANK;
        endcase
        return segBits;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low segment lookup; the caller registers
// the result.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hex_to_seg(nibble_i);
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner: steps one digit per scan_clk rising edge,
// with an all-off gap before each digit and a per-frame data latch.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic [2:0]  cur_digit
);

    localparam int         CNT_W      = $clog2(BLANK_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0] LAST_IDX   = 3'(DIGITS - 1);

    scan_state_e       state_q;
    logic [2:0]        idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              sync3_q;
    logic [31:0]       frameData_q;
    logic [7:0]        frameDp_q;
    logic [7:0]        frameEn_q;
    logic [7:0]        an_q;
    logic [6:0]        seg_q;
    logic              segDp_q;

    logic              tick;
    logic [2:0]        idx_d;
    logic              loadFrame_d;
    logic [31:0]       showData_d;
    logic [7:0]        showDp_d;
    logic [7:0]        showEn_d;
    logic [3:0]        showNibble_d;
    logic [6:0]        decodedSeg_d;

    assign tick = sync2_q & ~sync3_q;

    // The digit about to be shown, and the frame it belongs to: when the scan
    // wraps to digit 0 the live inputs are used because they are latched on
    // that same edge.
    always_comb begin
        idx_d        = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        loadFrame_d  = (idx_d == 3'd0);
        showData_d   = loadFrame_d ? data     : frameData_q;
        showDp_d     = loadFrame_d ? dp       : frameDp_q;
        showEn_d     = loadFrame_d ? digit_en : frameEn_q;
        showNibble_d = showData_d[{idx_d, 2'b00} +: 4];
    end

    seg7_decode u_decode (
        .nibble_i (showNibble_d),
        .seg_o    (decodedSeg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            frameData_q <= 32'd0;
            frameDp_q   <= 8'd0;
            frameEn_q   <= 8'd0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            segDp_q     <= 1'b1;
        end else begin
            sync1_q <= scan_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;

            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= BLANK;
                        idx_q   <= LAST_IDX;
                        cnt_q   <= '0;
                    end
                end

                // Ticks arriving during the gap are dropped, not queued.
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= SHOW;
                        idx_q   <= idx_d;
                        cnt_q   <= '0;
                        if (loadFrame_d) begin
                            frameData_q <= data;
                            frameDp_q   <= dp;
                            frameEn_q   <= digit_en;
                        end
                        an_q    <= showEn_d[idx_d] ? ~(8'd1 << idx_d) : AN_OFF;
                        seg_q   <= decodedSeg_d;
                        segDp_q <= ~showDp_d[idx_d];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                SHOW: begin
                    if (tick) begin
                        state_q <= BLANK;
                        cnt_q   <= '0;
                        an_q    <= AN_OFF;
                        seg_q   <= SEG_BLANK;
                        segDp_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    an_q    <= AN_OFF;
                    seg_q   <= SEG_BLANK;
                    segDp_q <= 1'b1;
                end
            endcase
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign seg_dp    = segDp_q;
    assign cur_digit = idx_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan against a time-based
// reference model of the scan sequence.
module tb_seg7_scan;

    localparam int DIGITS = 8;
    localparam int BLANK  = 16;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_clk;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [2:0]  cur_digit;

    int errorCount = 0;
    int checkCount = 0;
    int phase = 0;
    int period = 40;
    int highTime = 20;

    seg7_scan #(.DIGITS(DIGITS), .BLANK_CYCLES(BLANK)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_clk  (scan_clk),
        .data      (data),
        .dp        (dp),
        .digit_en  (digit_en),
        .an        (an),
        .seg       (seg),
        .seg_dp    (seg_dp),
        .cur_digit (cur_digit)
    );

    always #5 clk = ~clk;

    // Reference model: a digit becomes visible BLANK edges after an accepted
    // tick; a tick is accepted only while idle or while a digit is showing.
    int          edgeNum = 0;
    int          showEdge = 0;
    int          nextDigit = 0;
    bit          modelIdle = 1'b1;
    bit          expShowing = 1'b0;
    bit          scanHist [4] = '{0, 0, 0, 0};
    logic [31:0] mFrameData = '0;
    logic [7:0]  mFrameDp = '0;
    logic [7:0]  mFrameEn = '0;
    logic [7:0]  expAn = 8'hFF;
    logic [6:0]  expSeg = 7'h7F;
    logic        expDp = 1'b1;
    int          expCur = 0;

    always @(posedge clk) begin
        bit tickNow;
        int digit;
        edgeNum++;
        if (rst) begin
            scanHist   = '{0, 0, 0, 0};
            modelIdle  = 1'b1;
            expShowing = 1'b0;
            nextDigit  = 0;
            mFrameData = '0;
            mFrameDp   = '0;
            mFrameEn   = '0;
            expAn      = 8'hFF;
            expSeg     = 7'h7F;
            expDp      = 1'b1;
            expCur     = 0;
        end else begin
            scanHist[3] = scanHist[2];
            scanHist[2] = scanHist[1];
            scanHist[1] = scanHist[0];
            scanHist[0] = scan_clk;
            tickNow = scanHist[2] && !scanHist[3];
            if (!modelIdle && edgeNum == showEdge) begin
                digit     = nextDigit;
                nextDigit = (digit + 1) % DIGITS;
                if (digit == 0) begin
                    mFrameData = data;
                    mFrameDp   = dp;
                    mFrameEn   = digit_en;
                end
                expAn      = mFrameEn[digit] ? 8'(255 - (1 << digit)) : 8'hFF;
                expSeg     = HEX_TAB[(mFrameData >> (4 * digit)) & 32'hF];
                expDp      = !mFrameDp[digit];
                expCur     = digit;
                expShowing = 1'b1;
            end else if (tickNow && (modelIdle || edgeNum > showEdge)) begin
                modelIdle  = 1'b0;
                expShowing = 1'b0;
                showEdge   = edgeNum + BLANK;
                expAn      = 8'hFF;
                expSeg     = 7'h7F;
                expDp      = 1'b1;
            end
        end
    end

    function automatic int anodeIndex(input logic [7:0] a);
        for (int i = 0; i < 8; i++) begin
            if (a === 8'(255 - (1 << i))) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; scan_clk = 1'b0;
        data = 32'h76543210; dp = 8'h01; digit_en = 8'hFF;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({an, seg, seg_dp, cur_digit} !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
            errorCount++;
            $display("[TB] FAIL reset_hold an/seg/dp/cur actual=%h/%h/%b/%0d required=ff/7f/1/0", an, seg, seg_dp, cur_digit);
        end
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checkCount++;
            if ({an, seg, seg_dp, cur_digit} !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
                errorCount++;
                $display("[TB] FAIL reset_static cycle %0d actual=%h/%h/%b/%0d required=ff/7f/1/0", c, an, seg, seg_dp, cur_digit);
            end
        end
    endtask

    task automatic test_scan();
        int expectNext = 0;
        int lastD = -1;
        int shows = 0;
        int d;
        period = 40; highTime = 20; phase = 0;
        data = 32'h76543210; dp = 8'h01; digit_en = 8'hFF;
        for (int c = 0; c < 700; c++) begin
            scan_clk = (phase % period) < highTime; phase++;
            @(negedge clk);
            checkCount++;
            if ({an, seg, seg_dp} !== {expAn, expSeg, expDp}) begin
                errorCount++;
                $display("[TB] FAIL scan_model an/seg/dp actual=%h/%h/%b required=%h/%h/%b", an, seg, seg_dp, expAn, expSeg, expDp);
            end
            d = anodeIndex(an);
            if (an !== 8'hFF) begin
                checkCount++;
                if (d < 0 || seg !== HEX_TAB[d] || seg_dp !== (d != 0)) begin
                    errorCount++;
                    $display("[TB] FAIL scan_table an=%h seg actual=%h dp actual=%b", an, seg, seg_dp);
                end
                if (d != lastD) begin
                    checkCount++;
                    if (d != expectNext) begin
                        errorCount++;
                        $display("[TB] FAIL scan_order digit actual=%0d required=%0d", d, expectNext);
                    end
                    expectNext = (d + 1) % DIGITS;
                    shows++;
                end
            end
            lastD = d;
        end
        checkCount++;
        if (shows < 16) begin
            errorCount++;
            $display("[TB] FAIL scan_progress digits shown actual=%0d required>=16", shows);
        end
    endtask

    task automatic test_random_scan();
        for (int r = 0; r < 3; r++) begin
            period = $urandom_range(20, 60);
            highTime = $urandom_range(1, period - 1);
            phase = 0;
            data = $urandom; dp = 8'($urandom);
            for (int c = 0; c < 900; c++) begin
                if ($urandom_range(0, 199) == 0) data = $urandom;
                scan_clk = (phase % period) < highTime; phase++;
                @(negedge clk);
                checkCount++;
                if ({an, seg, seg_dp} !== {expAn, expSeg, expDp}) begin
                    errorCount++;
                    $display("[TB] FAIL random_model an/seg/dp actual=%h/%h/%b required=%h/%h/%b", an, seg, seg_dp, expAn, expSeg, expDp);
                end
                if (expShowing || modelIdle) begin
                    checkCount++;
                    if (cur_digit !== 3'(expCur)) begin
                        errorCount++;
                        $display("[TB] FAIL random_cur_digit actual=%0d required=%0d", cur_digit, expCur);
                    end
                end
            end
        end
    endtask

    task automatic test_frame_latch();
        int stage = 0;
        int newShown = 0;
        int d;
        period = 40; highTime = 20; phase = 0;
        data = 32'h76543210; dp = 8'h01; digit_en = 8'hFF;
        for (int c = 0; c < 1500 && stage < 4; c++) begin
            scan_clk = (phase % period) < highTime; phase++;
            @(negedge clk);
            checkCount++;
            if ({an, seg, seg_dp} !== {expAn, expSeg, expDp}) begin
                errorCount++;
                $display("[TB] FAIL latch_model an/seg/dp actual=%h/%h/%b required=%h/%h/%b", an, seg, seg_dp, expAn, expSeg, expDp);
            end
            d = anodeIndex(an);
            if (stage == 0 && expShowing && expCur == 0) stage = 1;
            else if (stage == 1 && expShowing && expCur == 3) begin
                data = 32'hFEDCBA98;
                stage = 2;
            end else if (stage >= 2 && d >= 0) begin
                if (stage == 2 && d == 0) stage = 3;
                checkCount++;
                if (seg !== HEX_TAB[stage == 2 ? d : d + 8]) begin
                    errorCount++;
                    $display("[TB] FAIL latch_digit%0d seg actual=%h required=%h", d, seg, HEX_TAB[stage == 2 ? d : d + 8]);
                end
                if (stage == 3 && d == 7) stage = 4;
            end
        end
        checkCount++;
        if (stage != 4) begin
            errorCount++;
            $display("[TB] FAIL latch_progress stage actual=%0d required=4", stage);
        end
    endtask

    task automatic test_edge_timing();
        int showStarts;
        int firstShow;
        bit prevShowing;
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 50; c++) begin
                scan_clk = 1'b0;
                @(negedge clk);
            end
            showStarts = 0; firstShow = -1;
            prevShowing = (an !== 8'hFF);
            for (int c = 0; c < 80; c++) begin
                scan_clk = (c >= 5 && c < 8) || (pass == 1 && c >= 15 && c < 18);
                @(negedge clk);
                checkCount++;
                if ({an, seg, seg_dp} !== {expAn, expSeg, expDp}) begin
                    errorCount++;
                    $display("[TB] FAIL edge_model pass %0d an/seg actual=%h/%h required=%h/%h", pass, an, seg, expAn, expSeg);
                end
                if (an !== 8'hFF && !prevShowing) begin
                    showStarts++;
                    if (firstShow < 0) firstShow = c;
                end
                prevShowing = (an !== 8'hFF);
            end
            checkCount++;
            if (showStarts !== 1 || firstShow !== 23) begin
                errorCount++;
                $display("[TB] FAIL edge_steps pass %0d steps/cycle actual=%0d/%0d required=1/23", pass, showStarts, firstShow);
            end
        end
    endtask

    task automatic test_enables();
        int stage = 0;
        int lit = 0;
        period = 40; highTime = 20; phase = 0;
        digit_en = 8'hA5;
        for (int c = 0; c < 1200; c++) begin
            scan_clk = (phase % period) < highTime; phase++;
            @(negedge clk);
            checkCount++;
            if ({an, seg, seg_dp} !== {expAn, expSeg, expDp}) begin
                errorCount++;
                $display("[TB] FAIL enable_model an/seg/dp actual=%h/%h/%b required=%h/%h/%b", an, seg, seg_dp, expAn, expSeg, expDp);
            end
            if (stage == 0 && expShowing && expCur == 0) stage = 1;
            if (stage == 1 && an !== 8'hFF) begin
                lit++;
                checkCount++;
                if (!(an inside {8'hFE, 8'hFB, 8'hDF, 8'h7F})) begin
                    errorCount++;
                    $display("[TB] FAIL enable_anode actual=%h required one of fe/fb/df/7f", an);
                end
            end
        end
        checkCount++;
        if (lit == 0) begin
            errorCount++;
            $display("[TB] FAIL enable_progress lit cycles actual=0 required>0");
        end
        digit_en = 8'hFF;
    endtask

    task automatic test_reset_midframe();
        int stage = 0;
        int d;
        logic [31:0] newData;
        period = 40; highTime = 20; phase = 0;
        for (int c = 0; c < 1500 && stage < 2; c++) begin
            scan_clk = (phase % period) < highTime; phase++;
            @(negedge clk);
            if (stage == 0 && expShowing && expCur == 0) stage = 1;
            else if (stage == 1 && expShowing && expCur == 5) stage = 2;
        end
        checkCount++;
        if (stage != 2 || an !== 8'hDF) begin
            errorCount++;
            $display("[TB] FAIL midreset_setup an actual=%h required=df", an);
        end
        rst = 1'b1;
        @(negedge clk);
        checkCount++;
        if ({an, seg, seg_dp, cur_digit} !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
            errorCount++;
            $display("[TB] FAIL midreset_blank actual=%h/%h/%b/%0d required=ff/7f/1/0", an, seg, seg_dp, cur_digit);
        end
        repeat (2) @(negedge clk);
        newData = $urandom;
        data = newData;
        rst = 1'b0;
        phase = 0;
        stage = 0;
        for (int c = 0; c < 200; c++) begin
            scan_clk = (phase % period) < highTime; phase++;
            @(negedge clk);
            checkCount++;
            if ({an, seg, seg_dp} !== {expAn, expSeg, expDp}) begin
                errorCount++;
                $display("[TB] FAIL midreset_model an/seg/dp actual=%h/%h/%b required=%h/%h/%b", an, seg, seg_dp, expAn, expSeg, expDp);
            end
            d = anodeIndex(an);
            if (stage == 0 && d >= 0) begin
                stage = 1;
                checkCount++;
                if (d != 0 || seg !== HEX_TAB[newData[3:0]]) begin
                    errorCount++;
                    $display("[TB] FAIL midreset_first digit/seg actual=%0d/%h required=0/%h", d, seg, HEX_TAB[newData[3:0]]);
                end
            end
        end
        checkCount++;
        if (stage != 1) begin
            errorCount++;
            $display("[TB] FAIL midreset_progress no digit shown after release");
        end
    endtask

    initial begin
        $display("[TB] seg7_scan bench start");
        test_reset();
        test_scan();
        test_random_scan();
        test_frame_latch();
        test_edge_timing();
        test_enables();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
